audio_stream_unpacker: RTL
==========================

Name: audio_stream_unpacker

Overview:
Sits between the FT2232 sync-FIFO receive path and the I2S transmitter inside the audio top. Accepts the host byte stream on a valid/ready handshake and assembles little-endian stereo PCM frames (left then right). Buffers frames in a small FIFO and hands one stereo frame to the I2S stage on each frame-rate request. Mutes the output and counts underruns when the host falls behind.

Parameters:
BITS_PER_SAMPLE, 24, sample width; 16 or 24 only; bytes per sample B = BITS_PER_SAMPLE/8
FIFO_DEPTH, 16, stereo frames buffered; power of two, 4..256

Ports:
clk_i  in  1  system clock; all logic synchronous to it
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  synchronous clear of assembler, FIFO and error flag
byte_i  in  8  received byte from the FT2232 RX path
byte_valid_i  in  1  byte_i valid
byte_ready_o  out  1  unpacker accepts byte_i this cycle
sample_req_i  in  1  one-cycle strobe from I2S at LRCK frame rate
left_o  out  BITS_PER_SAMPLE  left sample, two's complement
right_o  out  BITS_PER_SAMPLE  right sample, two's complement
sample_valid_o  out  1  one-cycle pulse: left_o/right_o updated from FIFO
underrun_o  out  1  one-cycle pulse: request found FIFO empty
underrun_count_o  out  16  saturating count of underruns
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  frames currently buffered

Behaviour:
- Reset (rst_i high, async): byte_ready_o=0, left_o=0, right_o=0, sample_valid_o=0, underrun_o=0, underrun_count_o=0, fifo_level_o=0, assembler empty. First cycle after release: byte_ready_o=1.
- Byte transfer occurs when byte_valid_i && byte_ready_o. Bytes fill LSB first: L byte0..L byte(B-1), then R byte0..R byte(B-1); byte index counter 0..2B-1.
- Assembler states: COLLECT (ready=1, counting bytes) -> HOLD when byte 2B-1 is accepted. HOLD (ready=0): frame is pushed when fifo_level_o < FIFO_DEPTH, then back to COLLECT. Push occurs the cycle after the last byte if space exists, so a full frame costs 2B+1 cycles minimum. HOLD persists while the FIFO is full.
- Push/pop use the registered level. A push at level==FIFO_DEPTH never happens, even with a simultaneous pop. The held frame pushes on the next cycle.
- On sample_req_i with level>0: pop. Next cycle: left_o/right_o = popped frame, sample_valid_o=1 for one cycle.
- On sample_req_i with level==0: next cycle: left_o=right_o=0 (mute), sample_valid_o=0, underrun_o=1 for one cycle, underrun_count_o += 1, saturating at 16'hFFFF. A push in that same cycle still succeeds; the frame is served on the next request.
- Simultaneous push and pop at 0<level<DEPTH: level unchanged, FIFO order preserved. Pointers wrap modulo FIFO_DEPTH.
- Outputs hold their last values between requests. sample_req_i pulses arriving in consecutive cycles are each serviced.
- flush_i (priority over push and pop, same cycle): assembler to COLLECT at index 0 (partial frame discarded), FIFO emptied, level=0, underrun_count_o=0, left_o=right_o=0; no sample_valid_o/underrun_o pulse. byte_ready_o stays 1, but the byte offered during the flush cycle is dropped.
- rst_i mid-frame: partial frame and FIFO contents lost; behaviour as reset.
- BITS_PER_SAMPLE outside {16,24}: elaboration-time $error.

Test Plan:
- 24-bit: bytes 01 02 03 04 05 06, then one sample_req_i -> next-cycle left_o=24'h030201, right_o=24'h060504, sample_valid_o pulse, fifo_level_o returns 0.
- Fill 16 frames with no requests -> fifo_level_o=16, byte_ready_o=0 after the 17th frame's last byte. One request -> frame 1 popped, held frame pushed next cycle, level back to 16.
- Request with empty FIFO -> left_o=right_o=0, underrun_o pulse, underrun_count_o=1. 65540 underruns -> count saturates at 16'hFFFF.
- 16-bit build: bytes 34 12 CD AB -> left_o=16'h1234, right_o=16'hABCD. Request coincident with a push at level 3 -> level stays 3, order correct.
- 3 bytes of a frame, then flush_i -> level 0, count 0. Next 6 bytes form a clean frame (no misalignment).
- Assert rst_i asynchronously mid-frame with 5 frames buffered -> all outputs zero immediately. After release, the first request gives an underrun.

Source files
------------

// File: rtl/audio_stream_unpacker.sv
// Assembles little-endian stereo PCM frames from a host byte stream, buffers them,
// and serves one frame per I2S frame request; mutes and counts underruns when empty.
module audio_stream_unpacker #(
  parameter int BITS_PER_SAMPLE = 24,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [7:0]                       byte_i,
  input  logic                             byte_valid_i,
  output logic                             byte_ready_o,
  input  logic                             sample_req_i,
  output logic [BITS_PER_SAMPLE-1:0]       left_o,
  output logic [BITS_PER_SAMPLE-1:0]       right_o,
  output logic                             sample_valid_o,
  output logic                             underrun_o,
  output logic [15:0]                      underrun_count_o,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level_o
);

  localparam int B  = BITS_PER_SAMPLE / 8;
  localparam int NB = 2 * B;
  localparam int IW = $clog2(NB);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 2 * BITS_PER_SAMPLE;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  if (BITS_PER_SAMPLE != 16 && BITS_PER_SAMPLE != 24) begin : g_bad_width
    $error("audio_stream_unpacker: BITS_PER_SAMPLE must be 16 or 24");
  end
  if (FIFO_DEPTH < 4 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("audio_stream_unpacker: FIFO_DEPTH must be a power of two in 4..256");
  end

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [FW-1:0]   frame;
  logic [FW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            accept;
  logic            push;
  logic            pop;

  assign accept       = byte_valid_i && byte_ready_o && !flush_i;
  // Full check uses the registered level only; a same-cycle pop never frees room.
  assign push         = (state == HOLD) && (level < DEPTH_L) && !flush_i;
  assign pop          = sample_req_i && (level != '0) && !flush_i;
  assign fifo_level_o = level;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= COLLECT;
      idx          <= '0;
      frame        <= '0;
      byte_ready_o <= 1'b0;
    end else if (flush_i) begin
      state        <= COLLECT;
      idx          <= '0;
      byte_ready_o <= 1'b1;
    end else begin
      case (state)
        COLLECT: begin
          byte_ready_o <= 1'b1;
          if (accept) begin
            frame[{idx, 3'b000} +: 8] <= byte_i;
            if (idx == LAST_IDX) begin
              idx          <= '0;
              state        <= HOLD;
              byte_ready_o <= 1'b0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (push) begin
            state        <= COLLECT;
            byte_ready_o <= 1'b1;
          end
        end
        default: begin
          state        <= COLLECT;
          byte_ready_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= frame;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      left_o           <= '0;
      right_o          <= '0;
      sample_valid_o   <= 1'b0;
      underrun_o       <= 1'b0;
      underrun_count_o <= '0;
    end else begin
      sample_valid_o <= 1'b0;
      underrun_o     <= 1'b0;
      if (flush_i) begin
        left_o           <= '0;
        right_o          <= '0;
        underrun_count_o <= '0;
      end else if (sample_req_i) begin
        if (level != '0) begin
          {right_o, left_o} <= mem[rd_ptr];
          sample_valid_o    <= 1'b1;
        end else begin
          left_o     <= '0;
          right_o    <= '0;
          underrun_o <= 1'b1;
          if (underrun_count_o != 16'hFFFF) underrun_count_o <= underrun_count_o + 16'd1;
        end
      end
    end
  end

endmodule
